ex_mem_arbiter: RTL and testbench
=================================

Name: ex_mem_arbiter

Overview:
- Sequences and arbitrates the single-port data memory / MMR resource that sits behind the execute stage's address datapath.
- Requester 0 is the pipeline memory port. It carries the EX-stage mem_flag (LW, LB, SW, SB, loadnoc), the ALU-computed address and the store data.
- Requester 1 is the NoC/MMR side port.
- The block grants one transaction at a time, drives the memory handshake, formats byte lanes, stalls the pipeline until its access completes, and aborts on a timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 because the byte-lane logic assumes 4 lanes.
- STARVE_LIM, 4, number of consecutive cycles the NoC port may lose arbitration before it gets forced priority.
- TIMEOUT, 16, maximum cycles to wait for m_ready before aborting.

Ports:
- clk  in  1  clock; all flops on rising edge.
- reset  in  1  asynchronous active-low reset.
- p_valid  in  1  pipeline request present; held until p_stall falls.
- p_flag  in  3  request code: 001 LW, 111 LB, 010 SW, 100 SB, 011 loadnoc (write). Any other code is no-op.
- p_addr  in  ADDR_W  ALU-computed byte address.
- p_wdata  in  DATA_W  store data.
- p_stall  out  1  freezes the pipeline while the pipeline access is pending.
- p_rdata  out  DATA_W  load result, valid in the cycle p_stall drops.
- n_req  in  1  NoC request; held until n_ack.
- n_we  in  1  NoC write (1) or read (0); always a full word.
- n_addr  in  ADDR_W  NoC address.
- n_wdata  in  DATA_W  NoC write data.
- n_ack  out  1  one-cycle completion pulse.
- n_rdata  out  DATA_W  NoC read data, valid with n_ack.
- m_req  out  1  memory request, held until m_ready.
- m_we  out  1  memory write enable.
- m_be  out  4  byte enables.
- m_addr  out  ADDR_W  word-aligned address (low 2 bits zero).
- m_wdata  out  DATA_W  memory write data.
- m_ready  in  1  memory completion; m_rdata valid in the same cycle.
- m_rdata  in  DATA_W  memory read data.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0 except p_stall, which is the combinational p_valid & ~p_done (p_done=0 in reset). Starve and timeout counters are 0; latched request registers are 0.
- States: IDLE, BUSY_P, BUSY_N, DONE_P, DONE_N.
- IDLE arbitration, evaluated each cycle:
  - p_valid with a legal p_flag → BUSY_P.
  - Otherwise n_req → BUSY_N.
  - If both request and starve_cnt == STARVE_LIM, the NoC wins.
  - starve_cnt increments when the NoC loses while requesting; it clears on an NoC grant or when n_req=0.
- p_valid with an illegal flag: no memory access; p_stall stays 0, because p_done is forced to 1 combinationally for illegal flags.
- On grant: latch we, be, address and data. m_req is asserted from registers starting the next cycle, so arbitration-to-m_req latency is 1 cycle.
- Byte-lane rules:
  - LW / SW / loadnoc / NoC: be=1111.
  - LB / SB: be = 1 << p_addr[1:0].
  - SB: wdata = {4{p_wdata[7:0]}}.
  - m_addr = {addr[ADDR_W-1:2], 2'b00}.
- BUSY_x:
  - m_req=1 with stable fields.
  - On m_ready: capture the response and go to DONE_x.
  - LB response: byte lane addr[1:0] of m_rdata, sign-extended to 32 bits. LW response: m_rdata unchanged.
  - The timeout counter increments every BUSY cycle. When it reaches TIMEOUT-1 without m_ready: drop m_req, set err, go to DONE_x with rdata = 0.
- DONE_P: p_done=1 for one cycle, so p_stall=0 and p_rdata is valid; then IDLE.
- DONE_N: n_ack=1 for one cycle with n_rdata; then IDLE.
- Minimum transaction length: grant cycle + 1 BUSY cycle + 1 DONE cycle = 3 cycles. Back-to-back grants are possible on the cycle after DONE.
- Timeout and m_ready in the same cycle: m_ready wins, err is not set.
- Requests arriving during BUSY/DONE wait; nothing is queued beyond the held request lines.
- Reset mid-transaction: m_req is dropped immediately and the transaction is lost. The requester re-issues after reset because its request lines are held.
- An m_ready received while in IDLE is ignored.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - flag constants LW=001, LB=111, SW=010, SB=100, LOADNOC=011;
  - the state encoding;
  - the BE_WORD constant.
- One sub-module, mem_byte_lane: combinational; maps (flag, addr[1:0], wdata, rdata) to be, formatted wdata and sign-extended load data. It is shared by the request and response paths.

Test Plan:
- LW, p_addr=0x104, m_ready 2 cycles after m_req with m_rdata=0xDEADBEEF → m_addr=0x104, be=1111, p_stall high 4 cycles, p_rdata=0xDEADBEEF.
- LB p_addr=0x203, m_rdata=0x80112233 → be=1000, p_rdata=0xFFFFFF80. SB p_addr=0x201, p_wdata=0x5A → be=0010, m_wdata=0x5A5A5A5A.
- p_valid and n_req both held continuously, memory ready in 1 cycle → pipeline wins the first 4 grants, NoC wins the 5th (STARVE_LIM=4), and starve_cnt then clears.
- m_ready never asserted on SW → m_req drops after 16 BUSY cycles, err=1 (sticky), p_stall falls.
- NoC read at 0x40 with reset asserted in the BUSY cycle → m_req=0 immediately, state IDLE. After reset is released the held n_req re-grants and n_ack pulses once.
- p_flag=000 with p_valid=1 → no m_req, p_stall=0, NoC request granted the same cycle.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_mem_pkg                                                        |
// | Request codes, arbiter state encoding and byte-enable constants.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package riscv_mem_pkg;

  localparam logic [2:0] LW      = 3'b001;
  localparam logic [2:0] LB      = 3'b111;
  localparam logic [2:0] SW      = 3'b010;
  localparam logic [2:0] SB      = 3'b100;
  localparam logic [2:0] LOADNOC = 3'b011;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_P = 3'd1;
  localparam logic [2:0] BUSY_N = 3'd2;
  localparam logic [2:0] DONE_P = 3'd3;
  localparam logic [2:0] DONE_N = 3'd4;

  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic flag_legal(input logic [2:0] flag);
    return (flag == LW) || (flag == LB) || (flag == SW) ||
           (flag == SB) || (flag == LOADNOC);
  endfunction

  // loadnoc pushes a word out through the MMR space, so it is a write
  function automatic logic flag_is_write(input logic [2:0] flag);
    return (flag == SW) || (flag == SB) || (flag == LOADNOC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_byte_lane                                                        |
// | Byte-enable generation, store replication and load sign extension.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_byte_lane
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  flag,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_fmt,
  output logic [31:0] rdata_fmt
);

  logic [7:0] w_rbyte;

  always_comb begin
    case (lane)
      2'd0:    w_rbyte = rdata[7:0];
      2'd1:    w_rbyte = rdata[15:8];
      2'd2:    w_rbyte = rdata[23:16];
      default: w_rbyte = rdata[31:24];
    endcase
  end

  always_comb begin
    be        = BE_WORD;
    wdata_fmt = wdata;
    rdata_fmt = rdata;
    if ((flag == LB) || (flag == SB)) be = 4'b0001 << lane;
    if (flag == SB) wdata_fmt = {4{wdata[7:0]}};
    if (flag == LB) rdata_fmt = {{24{w_rbyte[7]}}, w_rbyte};
  end

endmodule
`default_nettype wire

// File: rtl/ex_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_mem_arbiter                                                       |
// | Arbitrates pipeline and NoC access to the single-port data memory.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ex_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_valid,
  input  logic [2:0]        p_flag,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              n_req,
  input  logic              n_we,
  input  logic [ADDR_W-1:0] n_addr,
  input  logic [DATA_W-1:0] n_wdata,
  output logic              n_ack,
  output logic [DATA_W-1:0] n_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  localparam int C_SV_W = $clog2(STARVE_LIM + 1);
  localparam int C_TO_W = $clog2(TIMEOUT + 1);

  logic [2:0]        r_state;
  logic [2:0]        r_flag;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_p_rdata;
  logic [DATA_W-1:0] r_n_rdata;
  logic [C_SV_W-1:0] r_starve_cnt;
  logic [C_TO_W-1:0] r_tmo_cnt;
  logic              r_err;

  logic              w_idle;
  logic              w_busy;
  logic              w_p_legal;
  logic              w_p_req;
  logic              w_starved;
  logic              w_grant_p;
  logic              w_grant_n;
  logic              w_timeout;
  logic              w_p_done;
  logic [2:0]        w_bl_flag;
  logic [1:0]        w_bl_lane;
  logic [3:0]        w_bl_be;
  logic [DATA_W-1:0] w_bl_wdata;
  logic [DATA_W-1:0] w_bl_rdata;

  assign w_idle    = (r_state == IDLE);
  assign w_busy    = (r_state == BUSY_P) || (r_state == BUSY_N);
  assign w_p_legal = flag_legal(p_flag);
  assign w_p_req   = p_valid && w_p_legal;
  assign w_starved = (r_starve_cnt == C_SV_W'(STARVE_LIM));
  assign w_grant_n = w_idle && n_req && (!w_p_req || w_starved);
  assign w_grant_p = w_idle && w_p_req && !w_grant_n;
  // m_ready on the last allowed cycle still completes the access normally
  assign w_timeout = w_busy && !m_ready && (r_tmo_cnt == C_TO_W'(TIMEOUT - 1));

  // Illegal codes never touch memory, so they must not freeze the pipeline
  assign w_p_done  = (r_state == DONE_P) || !w_p_legal;
  assign p_stall   = p_valid && !w_p_done;

  // The lane formatter sees the live request while idle and the latched one while busy
  assign w_bl_flag = w_idle ? p_flag      : r_flag;
  assign w_bl_lane = w_idle ? p_addr[1:0] : r_addr[1:0];

  mem_byte_lane u_byte_lane (
    .flag      (w_bl_flag),
    .lane      (w_bl_lane),
    .wdata     (p_wdata),
    .rdata     (m_rdata),
    .be        (w_bl_be),
    .wdata_fmt (w_bl_wdata),
    .rdata_fmt (w_bl_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_flag    <= 3'b000;
      r_we      <= 1'b0;
      r_be      <= 4'b0000;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_p_rdata <= '0;
      r_n_rdata <= '0;
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tmo_cnt <= '0;
          if (w_grant_n) begin
            r_state <= BUSY_N;
            r_flag  <= LW;
            r_we    <= n_we;
            r_be    <= BE_WORD;
            r_addr  <= n_addr;
            r_wdata <= n_wdata;
          end else if (w_grant_p) begin
            r_state <= BUSY_P;
            r_flag  <= p_flag;
            r_we    <= flag_is_write(p_flag);
            r_be    <= w_bl_be;
            r_addr  <= p_addr;
            r_wdata <= w_bl_wdata;
          end
        end
        BUSY_P, BUSY_N: begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          if (m_ready || w_timeout) begin
            if (r_state == BUSY_P) begin
              r_state   <= DONE_P;
              r_p_rdata <= m_ready ? w_bl_rdata : '0;
            end else begin
              r_state   <= DONE_N;
              r_n_rdata <= m_ready ? m_rdata : '0;
            end
            if (!m_ready) r_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (!n_req || w_grant_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_p) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign m_req   = w_busy;
  assign m_we    = r_we;
  assign m_be    = r_be;
  assign m_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign m_wdata = r_wdata;
  assign p_rdata = r_p_rdata;
  assign n_ack   = (r_state == DONE_N);
  assign n_rdata = r_n_rdata;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ex_mem_arbiter                                                    |
// | Directed self-checking bench for ex_mem_arbiter.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ex_mem_arbiter;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid;
  logic [2:0]  p_flag;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic        p_stall;
  logic [31:0] p_rdata;
  logic        n_req;
  logic        n_we;
  logic [31:0] n_addr;
  logic [31:0] n_wdata;
  logic        n_ack;
  logic [31:0] n_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        err;

  int n_cmp = 0;
  int n_mis = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  ex_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_flag(p_flag), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata),
    .n_req(n_req), .n_we(n_we), .n_addr(n_addr), .n_wdata(n_wdata),
    .n_ack(n_ack), .n_rdata(n_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .err(err)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; p_valid = 1'b0; p_flag = 3'b000; p_addr = '0; p_wdata = '0;
    n_req = 1'b0; n_we = 1'b0; n_addr = '0; n_wdata = '0;
    m_ready = 1'b0; m_rdata = '0;
    #2;
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_p_stall", p_stall, 1'b0);
    chk1("rst_n_ack", n_ack, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk32("rst_p_rdata", p_rdata, 32'h0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // LW 0x104, m_ready two cycles after m_req rises
    stall_cnt = 0;
    p_valid = 1'b1; p_flag = LW; p_addr = 32'h104; #1;
    chk1("lw_grant_stall", p_stall, 1'b1);
    chk1("lw_grant_m_req", m_req, 1'b0);
    if (p_stall) stall_cnt++;
    cyc(); #1;
    chk1("lw_busy_m_req", m_req, 1'b1);
    chk32("lw_m_addr", m_addr, 32'h104);
    chk32("lw_m_be", {28'h0, m_be}, 32'hF);
    chk1("lw_m_we", m_we, 1'b0);
    if (p_stall) stall_cnt++;
    cyc(); #1;
    if (p_stall) stall_cnt++;
    cyc();
    m_ready = 1'b1; m_rdata = 32'hDEADBEEF; #1;
    if (p_stall) stall_cnt++;
    cyc();
    m_ready = 1'b0; #1;
    chk1("lw_done_stall", p_stall, 1'b0);
    chk32("lw_p_rdata", p_rdata, 32'hDEADBEEF);
    chk1("lw_done_m_req", m_req, 1'b0);
    chk32("lw_stall_cycles", stall_cnt, 32'd4);
    p_valid = 1'b0;
    cyc();

    // LB 0x203 picks byte lane 3 and sign-extends it
    p_valid = 1'b1; p_flag = LB; p_addr = 32'h203;
    cyc(); #1;
    chk32("lb_m_be", {28'h0, m_be}, 32'h8);
    chk32("lb_m_addr", m_addr, 32'h200);
    m_ready = 1'b1; m_rdata = 32'h80112233;
    cyc();
    m_ready = 1'b0; #1;
    chk32("lb_p_rdata", p_rdata, 32'hFFFFFF80);
    chk1("lb_done_stall", p_stall, 1'b0);
    p_valid = 1'b0;
    cyc();

    // SB 0x201 replicates the byte across all lanes
    p_valid = 1'b1; p_flag = SB; p_addr = 32'h201; p_wdata = 32'h0000005A;
    cyc(); #1;
    chk32("sb_m_be", {28'h0, m_be}, 32'h2);
    chk32("sb_m_wdata", m_wdata, 32'h5A5A5A5A);
    chk1("sb_m_we", m_we, 1'b1);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0; #1;
    chk1("sb_done_stall", p_stall, 1'b0);
    p_valid = 1'b0;
    cyc();

    // Both requesters held: four pipeline grants, then the NoC, then pipeline again
    p_valid = 1'b1; p_flag = LW; p_addr = 32'h10;
    n_req = 1'b1; n_we = 1'b0; n_addr = 32'h80;
    m_ready = 1'b1; m_rdata = 32'h12345678;
    for (int g = 0; g < 5; g++) begin
      cyc(); #1;
      chk32($sformatf("starve_addr_%0d", g), m_addr, (g < 4) ? 32'h10 : 32'h80);
      cyc(); #1;
      chk1($sformatf("starve_ack_%0d", g), n_ack, (g == 4) ? 1'b1 : 1'b0);
      if (g == 4) chk32("starve_n_rdata", n_rdata, 32'h12345678);
      cyc();
    end
    cyc(); #1;
    chk32("starve_cleared_addr", m_addr, 32'h10);
    n_req = 1'b0; p_valid = 1'b0;
    cyc();
    m_ready = 1'b0;
    cyc();

    // SW with no m_ready times out after 16 busy cycles
    p_valid = 1'b1; p_flag = SW; p_addr = 32'h300; p_wdata = 32'h11223344;
    cyc(); #1;
    chk1("to_first_err", err, 1'b0);
    chk32("to_m_wdata", m_wdata, 32'h11223344);
    stall_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      if (m_req) stall_cnt++;
      cyc(); #1;
    end
    chk32("to_busy_cycles", stall_cnt, 32'd16);
    chk1("to_m_req_drop", m_req, 1'b0);
    chk1("to_err", err, 1'b1);
    chk1("to_stall", p_stall, 1'b0);
    chk32("to_p_rdata", p_rdata, 32'h0);
    p_valid = 1'b0;
    cyc(); cyc(); #1;
    chk1("to_err_sticky", err, 1'b1);

    // NoC read at 0x40 interrupted by reset during BUSY
    n_req = 1'b1; n_we = 1'b0; n_addr = 32'h40;
    cyc(); #1;
    chk1("rr_busy_m_req", m_req, 1'b1);
    chk32("rr_m_addr", m_addr, 32'h40);
    reset = 1'b0; #1;
    chk1("rr_reset_m_req", m_req, 1'b0);
    chk1("rr_reset_err", err, 1'b0);
    cyc();
    reset = 1'b1; #1;
    chk1("rr_idle_n_ack", n_ack, 1'b0);
    cyc(); #1;
    chk1("rr_regrant_m_req", m_req, 1'b1);
    m_ready = 1'b1; m_rdata = 32'hCAFEF00D;
    cyc(); #1;
    chk1("rr_n_ack", n_ack, 1'b1);
    chk32("rr_n_rdata", n_rdata, 32'hCAFEF00D);
    n_req = 1'b0; m_ready = 1'b0;
    cyc(); #1;
    chk1("rr_n_ack_pulse", n_ack, 1'b0);

    // Illegal pipeline code: no stall, NoC write granted in the same cycle
    p_valid = 1'b1; p_flag = 3'b000;
    n_req = 1'b1; n_we = 1'b1; n_addr = 32'h44; n_wdata = 32'h99; #1;
    chk1("ill_stall", p_stall, 1'b0);
    chk1("ill_m_req_idle", m_req, 1'b0);
    cyc(); #1;
    chk1("ill_m_req", m_req, 1'b1);
    chk32("ill_m_addr", m_addr, 32'h44);
    chk1("ill_m_we", m_we, 1'b1);
    chk32("ill_m_wdata", m_wdata, 32'h99);
    chk32("ill_m_be", {28'h0, m_be}, 32'hF);
    m_ready = 1'b1;
    cyc(); #1;
    chk1("ill_n_ack", n_ack, 1'b1);
    chk1("ill_done_stall", p_stall, 1'b0);
    n_req = 1'b0; p_valid = 1'b0; m_ready = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
